mem_dp_mixed_be: RTL and testbench



---
 rtl/mem_dp_mixed_be.sv | 168 ++++++++++++++++
 tb/tb_mem_dp_mixed_be.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dp_mixed_be.sv
// Mixed-width true dual-port RAM: narrow lane port A, wide byte-enabled port B, one clock.
// Define MEM_DP_MIXED_CLEAR_EN to add the zero-fill clear engine that gates ready.
module mem_dp_mixed_be #(
    parameter int NARROW_W  = 8,
    parameter int RATIO     = 4,
    parameter int AW_B      = 10,
    parameter int OUT_REGS  = 2,
    parameter int RDW_MODE  = 0,
    parameter     INIT_FILE = "NONE",
    localparam int WIDE_W   = NARROW_W * RATIO,
    localparam int LW       = $clog2(RATIO),
    localparam int AW_A     = AW_B + LW
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                rden_a,
    input  logic                wren_a,
    input  logic [AW_A-1:0]     address_a,
    input  logic [NARROW_W-1:0] data_a,
    output logic [NARROW_W-1:0] q_a,
    input  logic                rden_b,
    input  logic                wren_b,
    input  logic [RATIO-1:0]    be_b,
    input  logic [AW_B-1:0]     address_b,
    input  logic [WIDE_W-1:0]   data_b,
    output logic [WIDE_W-1:0]   q_b,
    input  logic                clear_req,
    output logic                ready
);
    localparam int DEPTH  = 1 << AW_B;
    localparam int LANE_W = (LW > 0) ? LW : 1;

    logic [WIDE_W-1:0]   mem_q [DEPTH];
    logic                rd_a, wr_a, rd_b, wr_b;
    logic [AW_B-1:0]     word_a;
    logic [LANE_W-1:0]   lane_a;
    logic [WIDE_W-1:0]   new_a, new_b, word_rd_a, word_rd_b;
    logic [NARROW_W-1:0] s0_a_d, s0_a_q, s1_a_q;
    logic [WIDE_W-1:0]   s0_b_q, s1_b_q;
    logic                clr_we;
    logic [AW_B-1:0]     clr_addr;

    assign word_a = address_a[AW_A-1 -: AW_B];
    generate
        if (LW == 0) begin : g_lane_one
            assign lane_a = '0;
        end else begin : g_lane_many
            assign lane_a = address_a[LANE_W-1:0];
        end
    endgenerate

    assign rd_a = rden_a & ready;
    assign wr_a = wren_a & ready;
    assign rd_b = rden_b & ready;
    assign wr_b = wren_b & ready;

    // Post-write word contents seen from each port; port A is applied last so it wins a lane collision.
    always_comb begin
        new_b = mem_q[address_b];
        for (int k = 0; k < RATIO; k++)
            if (wr_b && be_b[k]) new_b[k*NARROW_W +: NARROW_W] = data_b[k*NARROW_W +: NARROW_W];
        if (wr_a && word_a == address_b) new_b[lane_a*NARROW_W +: NARROW_W] = data_a;
    end

    always_comb begin
        new_a = mem_q[word_a];
        for (int k = 0; k < RATIO; k++)
            if (wr_b && be_b[k] && address_b == word_a)
                new_a[k*NARROW_W +: NARROW_W] = data_b[k*NARROW_W +: NARROW_W];
        if (wr_a) new_a[lane_a*NARROW_W +: NARROW_W] = data_a;
    end

    assign word_rd_a = (RDW_MODE == 1) ? new_a : mem_q[word_a];
    assign word_rd_b = (RDW_MODE == 1) ? new_b : mem_q[address_b];
    assign s0_a_d    = word_rd_a[lane_a*NARROW_W +: NARROW_W];

    // Array contents are deliberately outside the reset domain.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
    end

    always @(posedge clock) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (wr_b) mem_q[address_b] <= new_b;
            if (wr_a) mem_q[word_a][lane_a*NARROW_W +: NARROW_W] <= data_a;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s0_a_q <= '0;
            s0_b_q <= '0;
            s1_a_q <= '0;
            s1_b_q <= '0;
        end else begin
            if (rd_a) s0_a_q <= s0_a_d;
            if (rd_b) s0_b_q <= word_rd_b;
            s1_a_q <= s0_a_q;
            s1_b_q <= s0_b_q;
        end
    end

    generate
        if (OUT_REGS == 1) begin : g_lat1
            assign q_a = s0_a_q;
            assign q_b = s0_b_q;
        end else begin : g_lat2
            assign q_a = s1_a_q;
            assign q_b = s1_b_q;
        end
    endgenerate

`ifdef MEM_DP_MIXED_CLEAR_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW_B-1:0] cnt_q, cnt_d;

    // The counter wraps to zero on the last word, leaving it ready for the next sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_IDLE;
            end
            default: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;
`else
    logic ready_q;
    logic unused_clear_req;

    assign unused_clear_req = clear_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end

    assign ready    = ready_q;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif
endmodule

// File: tb/tb_mem_dp_mixed_be.sv
// Directed bench for mem_dp_mixed_be: a 2-cycle/old-data instance and a 1-cycle/new-data instance
// driven in lockstep with identical stimulus.
module tb_mem_dp_mixed_be;
    logic        clk;
    logic        reset_n;
    logic        rden_a, wren_a, rden_b, wren_b, clear_req;
    logic [11:0] address_a;
    logic [7:0]  data_a;
    logic [3:0]  be_b;
    logic [9:0]  address_b;
    logic [31:0] data_b;
    logic [7:0]  q_a2, q_a1;
    logic [31:0] q_b2, q_b1;
    logic        ready2, ready1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start;

    mem_dp_mixed_be dut2 (
        .clock(clk), .reset_n(reset_n),
        .rden_a(rden_a), .wren_a(wren_a), .address_a(address_a), .data_a(data_a), .q_a(q_a2),
        .rden_b(rden_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b), .data_b(data_b),
        .q_b(q_b2), .clear_req(clear_req), .ready(ready2)
    );

    mem_dp_mixed_be #(.OUT_REGS(1), .RDW_MODE(1)) dut1 (
        .clock(clk), .reset_n(reset_n),
        .rden_a(rden_a), .wren_a(wren_a), .address_a(address_a), .data_a(data_a), .q_a(q_a1),
        .rden_b(rden_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b), .data_b(data_b),
        .q_b(q_b1), .clear_req(clear_req), .ready(ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [11:0] addr, input logic [7:0] d);
        wren_a = 1'b1; address_a = addr; data_a = d;
        tick();
        wren_a = 1'b0;
    endtask

    task automatic wr_b(input logic [9:0] addr, input logic [31:0] d, input logic [3:0] be);
        wren_b = 1'b1; address_b = addr; data_b = d; be_b = be;
        tick();
        wren_b = 1'b0;
    endtask

    // dut1 shows the word one edge after the strobe, dut2 one edge later.
    task automatic rd_b(input string tag, input logic [9:0] addr, input logic [31:0] exp);
        rden_b = 1'b1; address_b = addr;
        tick();
        rden_b = 1'b0;
        check({tag, "_l1"}, q_b1, exp);
        tick();
        check({tag, "_l2"}, q_b2, exp);
    endtask

    task automatic wait_ready(input string tag, input int expect_cycles);
        int n;
        n = 0;
        while (ready2 !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_cycles"}, n, expect_cycles);
        check({tag, "_ready1"}, ready1, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; clear_req = 1'b0;
        rden_a = 1'b0; wren_a = 1'b0; address_a = '0; data_a = '0;
        rden_b = 1'b0; wren_b = 1'b0; address_b = '0; data_b = '0; be_b = '0;
        #1;
        check("rst_qa2", q_a2, 0);
        check("rst_qb2", q_b2, 0);
        check("rst_qb1", q_b1, 0);
        check("rst_ready", ready2, 0);
        #11 reset_n = 1'b1;
`ifdef MEM_DP_MIXED_CLEAR_EN
        wait_ready("boot_clear", 1024);
`else
        tick();
        check("ready_first_edge", ready2, 1);
        check("ready_first_edge1", ready1, 1);
`endif

        // Lane assembly through port A, read back wide.
        wr_a(12'h005, 8'h11);
        wr_a(12'h006, 8'h22);
        wr_a(12'h007, 8'h33);
        wr_a(12'h004, 8'h00);
        rden_b = 1'b1; address_b = 10'h001;
        tick();
        rden_b = 1'b0;
        check("lanes_l1_at1", q_b1, 32'h33221100);
        check("lanes_l2_at1", q_b2, 32'h0);
        tick();
        check("lanes_l2_at2", q_b2, 32'h33221100);
        tick();
        check("lanes_l2_hold", q_b2, 32'h33221100);

        rden_a = 1'b1; address_a = 12'h006;
        tick();
        rden_a = 1'b0;
        check("rd_a_l1", q_a1, 8'h22);
        tick();
        check("rd_a_l2", q_a2, 8'h22);

        // Byte enables and the empty-enable no-op.
        wr_b(10'h010, 32'h0, 4'hF);
        wr_b(10'h010, 32'hAABBCCDD, 4'b0101);
        rd_b("be_0101", 10'h010, 32'h00BB00DD);
        wr_b(10'h010, 32'h12345678, 4'b0000);
        rd_b("be_none", 10'h010, 32'h00BB00DD);

        // Same-lane collision: A owns lane 1 of word 0x010.
        wren_a = 1'b1; address_a = 12'h041; data_a = 8'h5A;
        wren_b = 1'b1; address_b = 10'h010; data_b = 32'hFFFFFFFF; be_b = 4'hF;
        tick();
        wren_a = 1'b0; wren_b = 1'b0;
        rd_b("collide", 10'h010, 32'hFFFF5AFF);

        // Same-port read-during-write.
        wr_b(10'h020, 32'h01020304, 4'hF);
        wren_b = 1'b1; rden_b = 1'b1; address_b = 10'h020; data_b = 32'hDEADBEEF; be_b = 4'hF;
        tick();
        wren_b = 1'b0; rden_b = 1'b0;
        check("rdw_new_l1", q_b1, 32'hDEADBEEF);
        tick();
        check("rdw_old_l2", q_b2, 32'h01020304);

        // Cross-port read-during-write combined with a lane collision.
        wren_a = 1'b1; rden_a = 1'b1; address_a = 12'h081; data_a = 8'h77;
        wren_b = 1'b1; rden_b = 1'b1; address_b = 10'h020; data_b = 32'h11223344; be_b = 4'hF;
        tick();
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
        check("xrdw_qb_l1", q_b1, 32'h11227744);
        check("xrdw_qa_l1", q_a1, 8'h77);
        tick();
        check("xrdw_qb_l2", q_b2, 32'hDEADBEEF);
        check("xrdw_qa_l2", q_a2, 8'hBE);
        rd_b("xrdw_final", 10'h020, 32'h11227744);

        // Asynchronous reset in the middle of a read.
        rden_b = 1'b1; address_b = 10'h010;
        tick();
        rden_b = 1'b0;
        check("pre_rst_qb1", q_b1, 32'hFFFF5AFF);
        #2 reset_n = 1'b0;
        #1;
        check("arst_qb1", q_b1, 0);
        check("arst_qb2", q_b2, 0);
        check("arst_qa1", q_a1, 0);
        check("arst_qa2", q_a2, 0);
        #3 reset_n = 1'b1;
`ifdef MEM_DP_MIXED_CLEAR_EN
        wait_ready("rst_clear", 1024);
`else
        tick();
        check("rst_ready_again", ready2, 1);
        rd_b("mem_survives_rst", 10'h010, 32'hFFFF5AFF);
`endif

`ifdef MEM_DP_MIXED_CLEAR_EN
        // Clear sweep: writes during the sweep are dropped, a repeat request does not restart it.
        wr_b(10'h010, 32'hCAFEF00D, 4'hF);
        wr_a(12'h3FF, 8'h99);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        start = cyc;
        check("clr_ready_low", ready2, 0);
        repeat (4) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wr_a(12'h001, 8'hAB);
        while (ready2 !== 1'b1 && cyc - start < 3000) tick();
        check("clr_cycles", cyc - start, 1024);
        rd_b("clr_w0", 10'h000, 32'h0);
        rd_b("clr_w10", 10'h010, 32'h0);
        rd_b("clr_wff", 10'h0FF, 32'h0);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        wait_ready("mid_clear_rst", 1024);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
